// File: rtl/sprite_sched_pkg.sv
// Shared types, default widths and helpers for the sprite ROM scheduler.
package sprite_sched_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 2;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_ROM_LAT = 1;

  // Requester id width; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_arbiter
  import sprite_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant_c,
  output logic [ID_W-1:0]  winner_c,
  output logic             any_c
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant_c  = '0;
    winner_c = '0;
    any_c    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((32'(last) + k) % N_REQ);
      if (!any_c && req[idx]) begin
        any_c         = 1'b1;
        winner_c      = idx;
        grant_c[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Shares one sprite ROM read port among N_REQ renderers with round-robin
// burst grants; returns ROM data tagged with owner id and last-beat flag.
module sprite_rom_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned ROM_LAT = DEF_ROM_LAT,
  localparam int unsigned ID_W   = id_w(N_REQ)
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic                    rd_valid,
  output logic [ID_W-1:0]         rd_id,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_last
);

  localparam int unsigned TID_W = ROM_LAT * ID_W;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ROM_LAT-1:0] tv_q, tv_d;
  logic [ROM_LAT-1:0] tlast_q, tlast_d;
  logic [TID_W-1:0]   tid_q, tid_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]    arb_winner;
  logic               arb_any;

  logic [ADDR_W-1:0]  addr_arr [N_REQ];
  logic [LEN_W-1:0]   len_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req      (req),
    .last     (last_q),
    .grant_c  (arb_grant),
    .winner_c (arb_winner),
    .any_c    (arb_any)
  );

  // Burst FSM plus the {valid, id, last} tag line that tracks ROM latency.
  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    busy_d        = busy_q;
    rom_en_d      = rom_en_q;
    rom_address_d = rom_address_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_d        = last_q;
    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        rom_en_d = 1'b0;
        if (arb_any) begin
          state_d       = BURST;
          gnt_d         = arb_grant;
          busy_d        = 1'b1;
          rom_en_d      = 1'b1;
          rom_address_d = addr_arr[arb_winner];
          cnt_d         = len_arr[arb_winner];
          owner_d       = arb_winner;
          last_d        = arb_winner;
        end
      end
      BURST: begin
        if (cnt_q != '0) begin
          rom_address_d = rom_address_q + ADDR_W'(1);
          cnt_d         = cnt_q - LEN_W'(1);
        end else begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          rom_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    tv_d    = ROM_LAT'({tv_q, rom_en_q});
    tlast_d = ROM_LAT'({tlast_q, rom_en_q && (cnt_q == '0)});
    tid_d   = TID_W'({tid_q, (rom_en_q ? owner_q : ID_W'(0))});
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      rom_en_q      <= 1'b0;
      rom_address_q <= '0;
      cnt_q         <= '0;
      owner_q       <= '0;
      last_q        <= ID_W'(N_REQ - 1);
      tv_q          <= '0;
      tlast_q       <= '0;
      tid_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      rom_en_q      <= rom_en_d;
      rom_address_q <= rom_address_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      tv_q          <= tv_d;
      tlast_q       <= tlast_d;
      tid_q         <= tid_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign rom_en      = rom_en_q;
  assign rom_address = rom_address_q;
  assign rd_valid    = tv_q[ROM_LAT-1];
  assign rd_last     = tlast_q[ROM_LAT-1];
  assign rd_id       = tid_q[TID_W-1 -: ID_W];
  assign rd_data     = rom_q;

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Directed bench for sprite_rom_scheduler: one ROM_LAT=1 instance and one
// ROM_LAT=2 instance, each fed by a model ROM returning address[1:0].
module tb_sprite_rom_scheduler;

  logic       vga_clk;
  logic       reset_n;

  logic [3:0] req1;
  logic [7:0] a1 [4];
  logic [3:0] l1 [4];
  logic [31:0] req_addr1;
  logic [15:0] req_len1;
  logic [3:0] gnt1;
  logic       busy1, rom_en1, rd_valid1, rd_last1;
  logic [7:0] rom_address1;
  logic [1:0] rom_q1, rd_id1, rd_data1;

  logic [3:0] req2;
  logic [7:0] a2 [4];
  logic [3:0] l2 [4];
  logic [31:0] req_addr2;
  logic [15:0] req_len2;
  logic [3:0] gnt2;
  logic       busy2, rom_en2, rd_valid2, rd_last2;
  logic [7:0] rom_address2;
  logic [1:0] rom_q2, rq2_a, rd_id2, rd_data2;

  int checks = 0;
  int errors = 0;

  assign req_addr1 = {a1[3], a1[2], a1[1], a1[0]};
  assign req_len1  = {l1[3], l1[2], l1[1], l1[0]};
  assign req_addr2 = {a2[3], a2[2], a2[1], a2[0]};
  assign req_len2  = {l2[3], l2[2], l2[1], l2[0]};

  sprite_rom_scheduler #(.ROM_LAT(1)) u1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req1), .req_addr(req_addr1),
    .req_len(req_len1), .gnt(gnt1), .busy(busy1), .rom_en(rom_en1),
    .rom_address(rom_address1), .rom_q(rom_q1), .rd_valid(rd_valid1),
    .rd_id(rd_id1), .rd_data(rd_data1), .rd_last(rd_last1)
  );

  sprite_rom_scheduler #(.ROM_LAT(2)) u2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req2), .req_addr(req_addr2),
    .req_len(req_len2), .gnt(gnt2), .busy(busy2), .rom_en(rom_en2),
    .rom_address(rom_address2), .rom_q(rom_q2), .rd_valid(rd_valid2),
    .rd_id(rd_id2), .rd_data(rd_data2), .rd_last(rd_last2)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Model ROMs with one and two cycles of read latency.
  always @(posedge vga_clk) begin
    rom_q1 <= rom_address1[1:0];
    rq2_a  <= rom_address2[1:0];
    rom_q2 <= rq2_a;
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Single burst on u1 from idle; expected addresses/data derived from a and l.
  task automatic run_burst(input int id, input logic [7:0] a, input logic [3:0] l);
    req1[2'(id)] = 1'b1;
    a1[2'(id)]   = a;
    l1[2'(id)]   = l;
    step();
    for (int b = 0; b <= int'(l); b++) begin
      chk("burst_gnt", 32'(gnt1), (b == 0) ? (1 << id) : 0);
      chk("burst_rom_en", 32'(rom_en1), 1);
      chk("burst_busy", 32'(busy1), 1);
      chk("burst_addr", 32'(rom_address1), (int'(a) + b) & 255);
      if (b > 0) begin
        chk("burst_rd_valid", 32'(rd_valid1), 1);
        chk("burst_rd_id", 32'(rd_id1), id);
        chk("burst_rd_data", 32'(rd_data1), (int'(a) + b - 1) & 3);
        chk("burst_rd_last", 32'(rd_last1), 0);
      end
      if (b == 0) req1[2'(id)] = 1'b0;
      step();
    end
    chk("end_rom_en", 32'(rom_en1), 0);
    chk("end_busy", 32'(busy1), 0);
    chk("end_rd_valid", 32'(rd_valid1), 1);
    chk("end_rd_id", 32'(rd_id1), id);
    chk("end_rd_data", 32'(rd_data1), (int'(a) + int'(l)) & 3);
    chk("end_rd_last", 32'(rd_last1), 1);
    step();
    chk("after_rd_valid", 32'(rd_valid1), 0);
  endtask

  initial begin
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    req1 = '0;
    req2 = '0;
    for (int i = 0; i < 4; i++) begin
      a1[i] = '0; l1[i] = '0; a2[i] = '0; l2[i] = '0;
    end

    // Reset state.
    step();
    step();
    chk("rst_gnt", 32'(gnt1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_rom_en", 32'(rom_en1), 0);
    chk("rst_addr", 32'(rom_address1), 0);
    chk("rst_rd_valid", 32'(rd_valid1), 0);
    chk("rst_rd_id", 32'(rd_id1), 0);
    chk("rst_rd_last", 32'(rd_last1), 0);
    chk("rst_rd_valid2", 32'(rd_valid2), 0);
    reset_n = 1'b1;
    step();

    // Basic burst: requester 2, 0x40, four beats.
    run_burst(2, 8'h40, 4'd3);

    // Fairness after reset with all requests held and single-beat bursts.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a1[i] = 8'(16 * i);
      l1[i] = '0;
    end
    req1 = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(gnt1), 1 << ord[k]);
      chk("rr_rom_en", 32'(rom_en1), 1);
      chk("rr_addr", 32'(rom_address1), 16 * ord[k]);
      if (k == 4) req1 = '0;
      step();
      chk("rr_bubble_gnt", 32'(gnt1), 0);
      chk("rr_bubble_rom_en", 32'(rom_en1), 0);
      chk("rr_rd_id", 32'(rd_id1), ord[k]);
      chk("rr_rd_last", 32'(rd_last1), 1);
      step();
    end
    chk("rr_idle_gnt", 32'(gnt1), 0);

    // Address wrap 0xFE -> 0x00.
    run_burst(1, 8'hFE, 4'd2);

    // Reset during the third beat of a 16-beat burst.
    req1[3] = 1'b1;
    a1[3]   = 8'h80;
    l1[3]   = 4'd15;
    step();
    chk("mid_gnt", 32'(gnt1), 32'h8);
    req1[3] = 1'b0;
    step();
    step();
    chk("mid_addr", 32'(rom_address1), 32'h82);
    reset_n = 1'b0;
    step();
    chk("mid_rst_gnt", 32'(gnt1), 0);
    chk("mid_rst_busy", 32'(busy1), 0);
    chk("mid_rst_rom_en", 32'(rom_en1), 0);
    chk("mid_rst_addr", 32'(rom_address1), 0);
    chk("mid_rst_rd_valid", 32'(rd_valid1), 0);
    chk("mid_rst_rd_id", 32'(rd_id1), 0);
    chk("mid_rst_rd_last", 32'(rd_last1), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rd_valid", 32'(rd_valid1), 0);
      chk("post_rst_rom_en", 32'(rom_en1), 0);
    end
    run_burst(1, 8'h20, 4'd0);

    // Withdrawn request during another requester's burst.
    req1[0] = 1'b1;
    a1[0]   = 8'h30;
    l1[0]   = 4'd3;
    step();
    chk("wd_gnt", 32'(gnt1), 32'h1);
    req1[0] = 1'b0;
    step();
    req1[3] = 1'b1;
    step();
    req1[3] = 1'b0;
    chk("wd_addr", 32'(rom_address1), 32'h32);
    step();
    chk("wd_last_addr", 32'(rom_address1), 32'h33);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wd_no_gnt", 32'(gnt1), 0);
      chk("wd_no_read", 32'(rom_en1), 0);
    end

    // Two-cycle ROM latency on the second instance.
    req2[1] = 1'b1;
    a2[1]   = 8'h05;
    l2[1]   = 4'd3;
    step();
    for (int c = 0; c < 7; c++) begin
      chk("l2_gnt", 32'(gnt2), (c == 0) ? 32'h2 : 0);
      chk("l2_rom_en", 32'(rom_en2), (c <= 3) ? 1 : 0);
      if (c <= 3) chk("l2_addr", 32'(rom_address2), 5 + c);
      chk("l2_rd_valid", 32'(rd_valid2), (c >= 2 && c <= 5) ? 1 : 0);
      if (c >= 2 && c <= 5) begin
        chk("l2_rd_id", 32'(rd_id2), 1);
        chk("l2_rd_data", 32'(rd_data2), (5 + c - 2) & 3);
        chk("l2_rd_last", 32'(rd_last2), (c == 5) ? 1 : 0);
      end
      if (c == 0) req2[1] = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
